// File: rtl/pipeline_ctrl_chain_if.sv
// Purpose: bundles the pipeline-chain control, payload and status signals so the
//          chain and whatever drives it connect through a single port.
// Signals (named from the chain's point of view):
//   i_mode        0 = free run, 1 = debug step
//   i_step_req    one-cycle pulse starting a step burst
//   i_step_count  cycles per burst (0 behaves as 1)
//   i_stall_ext   global stall
//   i_stall_stage per-stage hold request
//   i_flush       per-stage clear
//   i_valid_in    valid of payload entering stage 0
//   i_data_in     payload entering stage 0
//   o_data        stage k at [k*DATA_W +: DATA_W]
//   o_valid       per-stage valid
//   o_advance     per-stage load strobe (combinational)
//   o_busy        step burst in progress
//   o_step_done   one-cycle burst completion pulse
//   o_cycle_cnt   run-enabled cycle count
// Modports: slave = chain side, master = driver side.
interface pipeline_ctrl_chain_if #(
  parameter int unsigned NUM_STAGES = 4,
  parameter int unsigned DATA_W     = 78,
  parameter int unsigned STEP_CNT_W = 16
);
  logic                         i_mode;
  logic                         i_step_req;
  logic [STEP_CNT_W-1:0]        i_step_count;
  logic                         i_stall_ext;
  logic [NUM_STAGES-1:0]        i_stall_stage;
  logic [NUM_STAGES-1:0]        i_flush;
  logic                         i_valid_in;
  logic [DATA_W-1:0]            i_data_in;
  logic [NUM_STAGES*DATA_W-1:0] o_data;
  logic [NUM_STAGES-1:0]        o_valid;
  logic [NUM_STAGES-1:0]        o_advance;
  logic                         o_busy;
  logic                         o_step_done;
  logic [31:0]                  o_cycle_cnt;

  modport slave (
    input  i_mode, i_step_req, i_step_count, i_stall_ext, i_stall_stage, i_flush,
           i_valid_in, i_data_in,
    output o_data, o_valid, o_advance, o_busy, o_step_done, o_cycle_cnt
  );

  modport master (
    output i_mode, i_step_req, i_step_count, i_stall_ext, i_stall_stage, i_flush,
           i_valid_in, i_data_in,
    input  o_data, o_valid, o_advance, o_busy, o_step_done, o_cycle_cnt
  );
endinterface

// File: rtl/pipeline_ctrl_chain.sv
// Purpose: chain of NUM_STAGES pipeline registers with valid bits, a per-stage
//          hold/flush/bubble network and a debug run/step controller. Stalling
//          stage k freezes stages 0..k and inserts a bubble into stage k+1.
// Ports:
//   i_clk    clock
//   i_rst_n  asynchronous active-low reset
//   io_bus   pipeline_ctrl_chain_if.slave (controls, payload in, stage state out)
module pipeline_ctrl_chain #(
  parameter int unsigned NUM_STAGES = 4,
  parameter int unsigned DATA_W     = 78,
  parameter int unsigned STEP_CNT_W = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  pipeline_ctrl_chain_if.slave   io_bus
);

  typedef enum logic [1:0] {StIdle, StStep, StDone} state_e;

  state_e                  r_state, w_state_nxt;
  logic [STEP_CNT_W-1:0]   r_remaining, w_remaining_nxt;
  logic                    r_busy, r_step_done;
  logic [31:0]             r_cycle_cnt;

  logic [DATA_W-1:0]       r_data [NUM_STAGES];
  logic [DATA_W-1:0]       w_data_nxt [NUM_STAGES];
  logic [NUM_STAGES-1:0]   r_valid, w_valid_nxt;

  logic                    w_run_en;
  logic [NUM_STAGES-1:0]   w_freeze;
  logic [DATA_W-1:0]       w_src_data [NUM_STAGES];
  logic [NUM_STAGES-1:0]   w_src_valid;
  logic [NUM_STAGES-1:0]   w_bubble;
  logic [NUM_STAGES*DATA_W-1:0] w_data_flat;

  assign w_run_en = ~io_bus.i_stall_ext & (~io_bus.i_mode | (r_state == StStep));

  // freeze[k] = any hold request at stage k or further downstream.
  always_comb begin
    w_freeze = '0;
    w_freeze[NUM_STAGES-1] = io_bus.i_stall_stage[NUM_STAGES-1];
    for (int k = int'(NUM_STAGES) - 2; k >= 0; k--) begin
      w_freeze[k] = w_freeze[k+1] | io_bus.i_stall_stage[k];
    end
  end

  // Upstream source of each stage; a stalled predecessor turns into a bubble.
  for (genvar g = 0; g < NUM_STAGES; g++) begin : g_src
    if (g == 0) begin : g_first
      assign w_src_data[g]  = io_bus.i_data_in;
      assign w_src_valid[g] = io_bus.i_valid_in;
      assign w_bubble[g]    = 1'b0;
    end else begin : g_rest
      assign w_src_data[g]  = r_data[g-1];
      assign w_src_valid[g] = r_valid[g-1];
      assign w_bubble[g]    = io_bus.i_stall_stage[g-1];
    end
  end

  always_comb begin
    w_valid_nxt = r_valid;
    for (int k = 0; k < int'(NUM_STAGES); k++) begin
      w_data_nxt[k] = r_data[k];
      if (w_run_en) begin
        if (io_bus.i_flush[k]) begin
          w_data_nxt[k]  = '0;
          w_valid_nxt[k] = 1'b0;
        end else if (w_freeze[k]) begin
          w_data_nxt[k]  = r_data[k];
          w_valid_nxt[k] = r_valid[k];
        end else if (w_bubble[k]) begin
          w_data_nxt[k]  = '0;
          w_valid_nxt[k] = 1'b0;
        end else begin
          w_data_nxt[k]  = w_src_data[k];
          w_valid_nxt[k] = w_src_valid[k];
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < int'(NUM_STAGES); k++) begin
        r_data[k] <= '0;
      end
      r_valid <= '0;
    end else begin
      for (int k = 0; k < int'(NUM_STAGES); k++) begin
        r_data[k] <= w_data_nxt[k];
      end
      r_valid <= w_valid_nxt;
    end
  end

  // Step controller.
  always_comb begin
    w_state_nxt     = r_state;
    w_remaining_nxt = r_remaining;
    unique case (r_state)
      StIdle: begin
        if (io_bus.i_mode && io_bus.i_step_req) begin
          w_remaining_nxt = (io_bus.i_step_count == '0) ? STEP_CNT_W'(1) : io_bus.i_step_count;
          w_state_nxt     = StStep;
        end
      end
      StStep: begin
        if (!io_bus.i_mode) begin
          w_state_nxt     = StIdle;
          w_remaining_nxt = '0;
        end else if (w_run_en) begin
          w_remaining_nxt = r_remaining - STEP_CNT_W'(1);
          if (r_remaining == STEP_CNT_W'(1)) begin
            w_state_nxt = StDone;
          end
        end
      end
      StDone: begin
        w_state_nxt     = StIdle;
        w_remaining_nxt = '0;
      end
      default: begin
        w_state_nxt     = StIdle;
        w_remaining_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= StIdle;
      r_remaining <= '0;
      r_busy      <= 1'b0;
      r_step_done <= 1'b0;
      r_cycle_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_remaining <= w_remaining_nxt;
      // Status flops track the state being entered so they stay pure registers.
      r_busy      <= (w_state_nxt == StStep);
      r_step_done <= (w_state_nxt == StDone);
      if (w_run_en) begin
        r_cycle_cnt <= r_cycle_cnt + 32'd1;
      end
    end
  end

  always_comb begin
    w_data_flat = '0;
    for (int k = 0; k < int'(NUM_STAGES); k++) begin
      w_data_flat[k*DATA_W +: DATA_W] = r_data[k];
    end
  end

  assign io_bus.o_data      = w_data_flat;
  assign io_bus.o_valid     = r_valid;
  assign io_bus.o_advance   = {NUM_STAGES{w_run_en}} & ~w_freeze & ~io_bus.i_flush;
  assign io_bus.o_busy      = r_busy;
  assign io_bus.o_step_done = r_step_done;
  assign io_bus.o_cycle_cnt = r_cycle_cnt;

endmodule

// File: tb/tb_pipeline_ctrl_chain.sv
module tb_pipeline_ctrl_chain;
  localparam int unsigned NS = 4;
  localparam int unsigned DW = 78;
  localparam int unsigned SW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  pipeline_ctrl_chain_if #(.NUM_STAGES(NS), .DATA_W(DW), .STEP_CNT_W(SW)) bus ();

  pipeline_ctrl_chain #(.NUM_STAGES(NS), .DATA_W(DW), .STEP_CNT_W(SW)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .io_bus (bus)
  );

  int n_checks = 0;
  int n_fail = 0;
  logic cmp_en = 1'b0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] pay(input int n);
    return {14'h2A5, 64'(n)};
  endfunction

  // Behavioural model: stage contents as an array, controller as a burst counter.
  logic [DW-1:0]   m_data [NS];
  logic [NS-1:0]   m_valid = '0;
  logic            m_busy = 1'b0;
  logic            m_done = 1'b0;
  int unsigned     m_left = 0;
  logic [31:0]     m_cnt = '0;

  initial for (int k = 0; k < int'(NS); k++) m_data[k] = '0;

  function automatic logic m_run();
    return !bus.i_stall_ext && (!bus.i_mode || m_busy);
  endfunction

  function automatic logic m_frozen(input int k);
    return (bus.i_stall_stage >> k) != '0;
  endfunction

  function automatic logic [NS-1:0] m_adv();
    logic [NS-1:0] a;
    for (int k = 0; k < int'(NS); k++) a[k] = m_run() && !m_frozen(k) && !bus.i_flush[k];
    return a;
  endfunction

  function automatic logic [NS*DW-1:0] m_flat();
    logic [NS*DW-1:0] f;
    for (int k = 0; k < int'(NS); k++) f[k*DW +: DW] = m_data[k];
    return f;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    logic [DW-1:0] nd [NS];
    logic [NS-1:0] nv;
    logic run, nb, ndn;
    int unsigned nl;
    if (!rst_n) begin
      for (int k = 0; k < int'(NS); k++) m_data[k] <= '0;
      m_valid <= '0;
      m_busy  <= 1'b0;
      m_done  <= 1'b0;
      m_left  <= 0;
      m_cnt   <= '0;
    end else begin
      run = m_run();
      nd = m_data;
      nv = m_valid;
      if (run) begin
        for (int k = 0; k < int'(NS); k++) begin
          if (bus.i_flush[k]) begin
            nd[k] = '0; nv[k] = 1'b0;
          end else if (m_frozen(k)) begin
            nd[k] = m_data[k]; nv[k] = m_valid[k];
          end else if (k > 0 && bus.i_stall_stage[k-1]) begin
            nd[k] = '0; nv[k] = 1'b0;
          end else if (k == 0) begin
            nd[k] = bus.i_data_in; nv[k] = bus.i_valid_in;
          end else begin
            nd[k] = m_data[k-1]; nv[k] = m_valid[k-1];
          end
        end
      end
      nb = m_busy; ndn = 1'b0; nl = m_left;
      if (m_done) begin
        nl = 0;
      end else if (m_busy) begin
        if (!bus.i_mode) begin
          nb = 1'b0; nl = 0;
        end else if (run) begin
          nl = m_left - 1;
          if (nl == 0) begin nb = 1'b0; ndn = 1'b1; end
        end
      end else if (bus.i_mode && bus.i_step_req) begin
        nb = 1'b1;
        nl = (bus.i_step_count == 0) ? 1 : int'(bus.i_step_count);
      end
      m_data  <= nd;
      m_valid <= nv;
      m_busy  <= nb;
      m_done  <= ndn;
      m_left  <= nl;
      m_cnt   <= m_cnt + (run ? 32'd1 : 32'd0);
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_data", 512'(bus.o_data), 512'(m_flat()));
      chk("cyc_valid", 512'(bus.o_valid), 512'(m_valid));
      chk("cyc_advance", 512'(bus.o_advance), 512'(m_adv()));
      chk("cyc_busy", 512'(bus.o_busy), 512'(m_busy));
      chk("cyc_done", 512'(bus.o_step_done), 512'(m_done));
      chk("cyc_cnt", 512'(bus.o_cycle_cnt), 512'(m_cnt));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_data"}, 512'(bus.o_data), 512'(0));
    chk({tag, "_valid"}, 512'(bus.o_valid), 512'(0));
    chk({tag, "_cnt"}, 512'(bus.o_cycle_cnt), 512'(0));
    chk({tag, "_busy"}, 512'(bus.o_busy), 512'(0));
    chk({tag, "_done"}, 512'(bus.o_step_done), 512'(0));
  endtask

  int busy_n, done_n, adv_n;

  initial begin
    bus.i_mode = 1'b0; bus.i_step_req = 1'b0; bus.i_step_count = '0;
    bus.i_stall_ext = 1'b0; bus.i_stall_stage = '0; bus.i_flush = '0;
    bus.i_valid_in = 1'b0; bus.i_data_in = '0;
    #1 rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    #1;
    check_zero("reset");
    cmp_en = 1'b1;

    // 1: free run fill
    bus.i_valid_in = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      bus.i_data_in = pay(n);
      tick();
    end
    chk("t1_stage3", 512'(bus.o_data[3*DW +: DW]), 512'(pay(1)));
    chk("t1_stage0", 512'(bus.o_data[0 +: DW]), 512'(pay(4)));
    chk("t1_valid", 512'(bus.o_valid), 512'(4'b1111));
    chk("t1_cnt", 512'(bus.o_cycle_cnt), 512'(4));

    // 2: one-cycle hold at stage 1
    bus.i_data_in = pay(5);
    bus.i_stall_stage = 4'b0010;
    #1 chk("t2_advance", 512'(bus.o_advance), 512'(4'b1100));
    tick();
    chk("t2_stage1", 512'(bus.o_data[1*DW +: DW]), 512'(pay(3)));
    chk("t2_stage2", 512'(bus.o_data[2*DW +: DW]), 512'(0));
    chk("t2_stage3", 512'(bus.o_data[3*DW +: DW]), 512'(pay(2)));
    chk("t2_valid", 512'(bus.o_valid), 512'(4'b1011));

    // 3: flush stage 0 while stage 2 holds
    bus.i_data_in = pay(6);
    bus.i_stall_stage = 4'b0100;
    bus.i_flush = 4'b0001;
    #1 chk("t3_advance", 512'(bus.o_advance), 512'(4'b1000));
    tick();
    chk("t3_stage0", 512'(bus.o_data[0 +: DW]), 512'(0));
    chk("t3_stage1", 512'(bus.o_data[1*DW +: DW]), 512'(pay(3)));
    chk("t3_valid", 512'(bus.o_valid), 512'(4'b0010));
    chk("t3_cnt", 512'(bus.o_cycle_cnt), 512'(6));
    bus.i_stall_stage = '0;
    bus.i_flush = '0;

    // 4: step burst of 3 with two external-stall cycles
    bus.i_mode = 1'b1;
    bus.i_data_in = pay(7);
    bus.i_step_count = 16'd3;
    bus.i_step_req = 1'b1;
    tick();
    bus.i_step_req = 1'b0;
    busy_n = 0; done_n = 0; adv_n = 0;
    for (int i = 0; i < 8; i++) begin
      bus.i_stall_ext = (i == 1 || i == 2);
      #1;
      busy_n += int'(bus.o_busy);
      done_n += int'(bus.o_step_done);
      adv_n  += int'(bus.o_advance != '0);
      tick();
    end
    bus.i_stall_ext = 1'b0;
    chk("t4_busy_cycles", 512'(busy_n), 512'(5));
    chk("t4_done_pulses", 512'(done_n), 512'(1));
    chk("t4_advances", 512'(adv_n), 512'(3));
    chk("t4_cnt", 512'(bus.o_cycle_cnt), 512'(9));

    // 5: count 0 runs one cycle; re-request during the burst is ignored
    bus.i_step_count = 16'd0;
    bus.i_step_req = 1'b1;
    tick();
    busy_n = 0; done_n = 0; adv_n = 0;
    for (int i = 0; i < 5; i++) begin
      bus.i_step_req = (i == 0);
      #1;
      busy_n += int'(bus.o_busy);
      done_n += int'(bus.o_step_done);
      adv_n  += int'(bus.o_advance != '0);
      tick();
    end
    bus.i_step_req = 1'b0;
    chk("t5_busy_cycles", 512'(busy_n), 512'(1));
    chk("t5_done_pulses", 512'(done_n), 512'(1));
    chk("t5_advances", 512'(adv_n), 512'(1));
    chk("t5_cnt", 512'(bus.o_cycle_cnt), 512'(10));

    // 6: mode drop mid-burst, then asynchronous reset between edges
    bus.i_step_count = 16'd5;
    bus.i_step_req = 1'b1;
    tick();
    bus.i_step_req = 1'b0;
    tick();
    chk("t6_busy_mid", 512'(bus.o_busy), 512'(1));
    chk("t6_cnt_mid", 512'(bus.o_cycle_cnt), 512'(11));
    bus.i_mode = 1'b0;
    done_n = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      done_n += int'(bus.o_step_done);
      chk("t6_busy_after", 512'(bus.o_busy), 512'(0));
    end
    chk("t6_no_done", 512'(done_n), 512'(0));
    #1 rst_n = 1'b0;
    #1 check_zero("t6_async_reset");
    @(posedge clk);
    #2 rst_n = 1'b1;
    bus.i_data_in = pay(9);
    tick();
    chk("t6_after_reset_cnt", 512'(bus.o_cycle_cnt), 512'(1));
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
